// File: rtl/avalon_multi_timer_pkg.sv
// Shared register map and per-channel flag layout for the multi-channel Avalon timer.
package avalon_multi_timer_pkg;

  localparam logic [2:0] OFS_STATUS   = 3'd0;
  localparam logic [2:0] OFS_CONTROL  = 3'd1;
  localparam logic [2:0] OFS_PERIOD   = 3'd2;
  localparam logic [2:0] OFS_SNAP     = 3'd3;
  localparam logic [2:0] OFS_PRESCALE = 3'd4;
  localparam logic [2:0] OFS_PEND     = 3'd5;

  localparam int STAT_TO    = 0;
  localparam int STAT_RUN   = 1;
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef struct packed {
    logic ito;
    logic cont;
    logic run;
    logic to;
  } ch_flags_t;

endpackage

// File: rtl/avalon_multi_timer_if.sv
// Avalon-MM slave bus plus the combined interrupt line of the timer block.
interface avalon_multi_timer_if #(
  parameter int AW = 5
);
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;

  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/avalon_multi_timer_channel.sv
// One timer channel: prescaler, down-counter, RUN/TO flags and its programmable registers.
module timer_channel
  import avalon_multi_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 16,
  parameter int RESET_PERIOD = 49999999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  offset,
  input  logic [31:0] writedata,
  output logic [31:0] rd_data,
  output logic        pend
);

  logic [CNT_W-1:0] cnt, period, snap;
  logic [PRE_W-1:0] prescale, pre_cnt;
  ch_flags_t        flags;

  logic wr_status, wr_ctrl, wr_period, wr_snap, wr_pre;
  logic start, stop, tick, timeout;

  assign wr_status = wr_en && (offset == OFS_STATUS);
  assign wr_ctrl   = wr_en && (offset == OFS_CONTROL);
  assign wr_period = wr_en && (offset == OFS_PERIOD);
  assign wr_snap   = wr_en && (offset == OFS_SNAP);
  assign wr_pre    = wr_en && (offset == OFS_PRESCALE);

  // A STOP freezes the counter at the value it holds during the stop write itself.
  assign start   = wr_ctrl && writedata[CTRL_START];
  assign stop    = wr_ctrl && writedata[CTRL_STOP] && !writedata[CTRL_START];
  assign tick    = flags.run && (pre_cnt == '0) && !stop;
  assign timeout = tick && (cnt == '0);
  assign pend    = flags.to && flags.ito;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= CNT_W'(RESET_PERIOD);
      period   <= CNT_W'(RESET_PERIOD);
      snap     <= '0;
      prescale <= '0;
      pre_cnt  <= '0;
      flags    <= '0;
    end else begin
      if (start || tick)
        pre_cnt <= prescale;
      else if (flags.run && !stop)
        pre_cnt <= pre_cnt - 1'b1;

      if (wr_period) begin
        period <= writedata[CNT_W-1:0];
        cnt    <= writedata[CNT_W-1:0];
      end else if (timeout) begin
        cnt <= period;
      end else if (tick) begin
        cnt <= cnt - 1'b1;
      end

      if (wr_period)
        flags.run <= 1'b0;
      else if (start)
        flags.run <= 1'b1;
      else if (stop || (timeout && !flags.cont))
        flags.run <= 1'b0;

      if (timeout)
        flags.to <= 1'b1;
      else if (wr_status)
        flags.to <= 1'b0;

      if (wr_ctrl) begin
        flags.ito  <= writedata[CTRL_ITO];
        flags.cont <= writedata[CTRL_CONT];
      end
      if (wr_snap) snap     <= cnt;
      if (wr_pre)  prescale <= writedata[PRE_W-1:0];
    end
  end

  // NOTE: rd_data gets a default before the case so no latch is inferred for unlisted offsets.
  always_comb begin
    rd_data = '0;
    case (offset)
      OFS_STATUS: begin
        rd_data[STAT_TO]  = flags.to;
        rd_data[STAT_RUN] = flags.run;
      end
      OFS_CONTROL: begin
        rd_data[CTRL_ITO]  = flags.ito;
        rd_data[CTRL_CONT] = flags.cont;
      end
      OFS_PERIOD:   rd_data = 32'(period);
      OFS_SNAP:     rd_data = 32'(snap);
      OFS_PRESCALE: rd_data = 32'(prescale);
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: rtl/avalon_multi_timer.sv
// Multi-channel interval timer: address decode, read mux, PEND vector and combined irq.
module avalon_multi_timer
  import avalon_multi_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 16,
  parameter int RESET_PERIOD = 49999999
) (
  input logic                clk,
  input logic                reset_n,
  avalon_multi_timer_if.slave bus
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int CH_BITS = (CH_W > 0) ? CH_W : 1;
  localparam int AW      = CH_W + 3;

  logic [CH_BITS-1:0] ch;
  logic [2:0]         offset;
  logic               ch_valid, rd_en, wr_en;
  logic [NUM_CH-1:0]  pend;
  logic [31:0]        ch_rd [NUM_CH];
  logic [31:0]        ch_word, rd_mux;

  // With a single channel there are no channel bits in the address at all.
  if (CH_W > 0) begin : g_ch
    assign ch = bus.address[AW-1:3];
  end else begin : g_no_ch
    assign ch = '0;
  end

  assign offset   = bus.address[2:0];
  assign ch_valid = 32'(ch) < NUM_CH;
  assign rd_en    = bus.chipselect && bus.write_n;
  assign wr_en    = bus.chipselect && !bus.write_n && ch_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    timer_channel #(
      .CNT_W       (CNT_W),
      .PRE_W       (PRE_W),
      .RESET_PERIOD(RESET_PERIOD)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_en && (32'(ch) == i)),
      .offset   (offset),
      .writedata(bus.writedata),
      .rd_data  (ch_rd[i]),
      .pend     (pend[i])
    );
  end

  always_comb begin
    ch_word = '0;
    rd_mux  = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (32'(ch) == i) ch_word = ch_rd[i];
    if (ch_valid) begin
      case (offset)
        OFS_PEND:   rd_mux = 32'(pend);
        3'd6, 3'd7: rd_mux = '0;
        default:    rd_mux = ch_word;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      if (rd_en) bus.readdata <= rd_mux;
      bus.irq <= |pend;
    end
  end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Scenario bench for avalon_multi_timer with a queue scoreboard of expected read values.
module tb_avalon_multi_timer;
  localparam int NUM_CH       = 5;
  localparam int RESET_PERIOD = 49999999;
  localparam int AW           = $clog2(NUM_CH) + 3;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] rd, e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_multi_timer_if #(.AW(AW)) bus ();

  avalon_multi_timer #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (32),
    .PRE_W       (16),
    .RESET_PERIOD(RESET_PERIOD)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic bus_write(input int ch, input int ofs, input logic [31:0] d);
    @(negedge clk);
    bus.address    = AW'(ch * 8 + ofs);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int ofs, output logic [31:0] d);
    @(negedge clk);
    bus.address    = AW'(ch * 8 + ofs);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(posedge clk);
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.readdata !== 32'd0) begin failures++; $display("FAIL reset_readdata got %0h want 0", bus.readdata); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b want 0", bus.irq); end
    @(negedge clk) reset_n = 1'b1;
    exp_q.push_back(32'(RESET_PERIOD)); bus_read(0, 2, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL reset_period got %0d want %0d", rd, e); end
    exp_q.push_back(32'd0); bus_read(0, 0, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL reset_status got %0h want %0h", rd, e); end
    exp_q.push_back(32'd0); bus_read(2, 4, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL reset_prescale got %0h want %0h", rd, e); end
  endtask

  task automatic test_continuous;
    int t0;
    bus_write(1, 2, 32'd9);
    bus_write(1, 4, 32'd0);
    bus_write(1, 1, 32'h7);
    t0 = cyc;
    wait_edge(t0 + 10);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_at_timeout got %b want 0", bus.irq); end
    wait_edge(t0 + 11);
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL irq_rise got %b want 1", bus.irq); end
    exp_q.push_back(32'h2); bus_read(0, 5, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL pend_vector got %0h want %0h", rd, e); end
    exp_q.push_back(32'h3); bus_read(1, 0, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL ch1_status_to got %0h want %0h", rd, e); end
    bus_write(1, 0, 32'h0);
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL irq_hold got %b want 1", bus.irq); end
    wait_edge(t0 + 15);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_fall got %b want 0", bus.irq); end
    wait_edge(t0 + 20);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_second_edge got %b want 0", bus.irq); end
    wait_edge(t0 + 21);
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL irq_period10 got %b want 1", bus.irq); end
    exp_q.push_back(32'h3); bus_read(1, 1, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL ch1_control got %0h want %0h", rd, e); end

    // STATUS write lands on the same edge as the third timeout: the set must win.
    wait_edge(t0 + 29);
    bus_write(1, 0, 32'h0);
    exp_q.push_back(32'h3); bus_read(1, 0, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL to_set_wins got %0h want %0h", rd, e); end
    bus_write(1, 0, 32'h0);
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL irq_before_clear got %b want 1", bus.irq); end
    wait_edge(t0 + 33);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_after_clear got %b want 0", bus.irq); end
    exp_q.push_back(32'h2); bus_read(1, 0, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL to_cleared got %0h want %0h", rd, e); end
    bus_write(1, 1, 32'h8);
    bus_write(1, 0, 32'h0);
    exp_q.push_back(32'h0); bus_read(1, 1, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL strobes_read0 got %0h want %0h", rd, e); end
  endtask

  task automatic test_one_shot;
    int t0;
    bus_write(2, 2, 32'd3);
    bus_write(2, 4, 32'd4);
    bus_write(2, 1, 32'h4);
    t0 = cyc;
    wait_edge(t0 + 18);
    exp_q.push_back(32'h2); bus_read(2, 0, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL oneshot_before got %0h want %0h", rd, e); end
    exp_q.push_back(32'h2); bus_read(2, 0, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL oneshot_edge got %0h want %0h", rd, e); end
    exp_q.push_back(32'h1); bus_read(2, 0, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL oneshot_after got %0h want %0h", rd, e); end
    wait_edge(t0 + 60);
    bus_write(2, 3, 32'h0);
    exp_q.push_back(32'd3); bus_read(2, 3, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL oneshot_counter got %0d want %0d", rd, e); end
    exp_q.push_back(32'h1); bus_read(2, 0, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL oneshot_stopped got %0h want %0h", rd, e); end
    exp_q.push_back(32'd4); bus_read(2, 4, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL prescale_rb got %0d want %0d", rd, e); end
  endtask

  task automatic test_snap_stop;
    int t0, s;
    bus_write(0, 2, 32'd100);
    bus_write(0, 1, 32'h4);
    t0 = cyc;
    wait_edge(t0 + 7);
    bus_write(0, 3, 32'h0);
    exp_q.push_back(32'd93); bus_read(0, 3, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL snap_value got %0d want %0d", rd, e); end
    bus_write(0, 1, 32'h8);
    s = cyc;
    exp_q.push_back(32'(100 - (s - 1 - t0)));
    wait_edge(s + 5);
    bus_write(0, 3, 32'h0);
    bus_read(0, 3, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL stop_hold got %0d want %0d", rd, e); end
    exp_q.push_back(32'h0); bus_read(0, 0, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL stop_run got %0h want %0h", rd, e); end
  endtask

  task automatic test_period_reload_and_range;
    bus_write(3, 1, 32'h4);
    repeat (3) @(posedge clk);
    #1;
    bus_write(3, 2, 32'd5);
    exp_q.push_back(32'h0); bus_read(3, 0, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL reload_run got %0h want %0h", rd, e); end
    bus_write(3, 3, 32'h0);
    exp_q.push_back(32'd5); bus_read(3, 3, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL reload_counter got %0d want %0d", rd, e); end
    exp_q.push_back(32'd5); bus_read(3, 2, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL reload_period got %0d want %0d", rd, e); end

    bus_write(NUM_CH, 2, 32'd77);
    bus_write(NUM_CH, 1, 32'h7);
    exp_q.push_back(32'h0); bus_read(NUM_CH, 2, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL oor_read got %0h want %0h", rd, e); end
    exp_q.push_back(32'd9); bus_read(1, 2, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL oor_alias got %0d want %0d", rd, e); end
    exp_q.push_back(32'(RESET_PERIOD)); bus_read(4, 2, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL oor_ch4 got %0d want %0d", rd, e); end
    exp_q.push_back(32'h0); bus_read(7, 5, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL oor_pend got %0h want %0h", rd, e); end
    exp_q.push_back(32'h0); bus_read(0, 6, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL ofs6_read got %0h want %0h", rd, e); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL oor_irq got %b want 0", bus.irq); end
  endtask

  initial begin
    test_reset;
    test_continuous;
    test_one_shot;
    test_snap_stop;
    test_period_reload_and_range;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
